// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types and defaults for the BIST response analyzer
//
// Purpose: analyzer FSM state type, default MISR/golden constants and the
// cycle counter width function shared by bist_response_analyzer and misr.
// Ports: none (package).

package bist_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    COMPACT = 3'd2,
    COMPARE = 3'd3,
    REPORT  = 3'd4
  } bist_state_e;

  localparam int          DEF_WIDTH   = 16;
  localparam logic [15:0] DEF_POLY    = 16'hB400;
  localparam logic [15:0] DEF_SEED    = 16'hFFFF;
  localparam logic [15:0] DEF_GOLDEN  = 16'h0000;
  localparam int          DEF_NCYCLES = 650;

  // One bit of headroom above what NCYCLES needs, so an over-long run is
  // still distinguishable from an exact one before the counter saturates.
  function automatic int count_width(input int ncycles);
    return $clog2(ncycles + 1) + 1;
  endfunction

endpackage

// File: rtl/misr.sv
// rtl/misr.sv - Galois multiple-input signature register
//
// Purpose: compacts one WIDTH-bit response word per enabled cycle into a
// signature. load re-seeds and takes priority over enable.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-high; sig returns to SEED
//   load   in   synchronous re-seed to SEED
//   enable in   compact data this cycle
//   data   in   WIDTH response word
//   sig    out  WIDTH current signature (registered)

module misr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(bist_pkg::DEF_POLY),
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (enable) begin
      // Shift left; the bit falling out of the MSB folds the polynomial back in.
      sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_response_analyzer.sv
// rtl/bist_response_analyzer.sv - MISR-based BIST response analyzer
//
// Purpose: follows the BIST controller's init/running/finish sequencing,
// compacts CUT responses into a MISR signature, counts compacted cycles and
// reports done/pass/fail against GOLDEN at the end of a run.
// Optional: define BIST_CYCLE_CHECK_EN to also require cycle_count==NCYCLES
// for a pass.
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous, active-high
//   init        in   arm / restart pulse (highest priority)
//   running     in   qualifies compaction of cut_out
//   finish      in   ends the run, triggers compare
//   cut_out     in   WIDTH CUT response
//   signature   out  WIDTH current MISR contents
//   cycle_count out  compacted cycle count, saturating
//   done        out  result valid, held until init/reset
//   pass        out  run matched
//   fail        out  run mismatched

module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] POLY    = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED    = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] GOLDEN  = WIDTH'(DEF_GOLDEN),
  parameter int               NCYCLES = DEF_NCYCLES
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              init,
  input  logic                              running,
  input  logic                              finish,
  input  logic [WIDTH-1:0]                  cut_out,
  output logic [WIDTH-1:0]                  signature,
  output logic [count_width(NCYCLES)-1:0]   cycle_count,
  output logic                              done,
  output logic                              pass,
  output logic                              fail
);

  localparam int CW = count_width(NCYCLES);

  bist_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;
  logic          misr_load;
  logic          misr_en;
  logic          match;

  misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk    (clk),
    .reset  (reset),
    .load   (misr_load),
    .enable (misr_en),
    .data   (cut_out),
    .sig    (signature)
  );

`ifdef BIST_CYCLE_CHECK_EN
  assign match = (signature == GOLDEN) && (cnt_q == CW'(NCYCLES));
`else
  assign match = (signature == GOLDEN);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;

    if (init) begin
      // init wins over running/finish in every state and always re-arms.
      state_d   = ARMED;
      misr_load = 1'b1;
      cnt_d     = '0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        ARMED, COMPACT: begin
          if (running) begin
            misr_en = 1'b1;
            if (cnt_q != {CW{1'b1}}) begin
              cnt_d = cnt_q + CW'(1);
            end
            state_d = COMPACT;
          end
          // A finish coinciding with running still compacts that last word.
          if (finish) begin
            state_d = COMPARE;
          end
        end
        COMPARE: begin
          done_d  = 1'b1;
          pass_d  = match;
          fail_d  = !match;
          state_d = REPORT;
        end
        REPORT: begin
          state_d = REPORT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign cycle_count = cnt_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;

endmodule
